// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S audio transmitter: frame geometry,
// the stereo sample pair, and the small state encodings used by the top.
package i2s_pkg;

    localparam int FRAME_BITS = 32;
    localparam int SAMPLE_W   = 16;
    localparam int DIV_W      = 8;
    localparam int POS_W      = 5;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] left;
        logic signed [SAMPLE_W-1:0] right;
    } stereo_t;

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_FULL
    } hold_state_t;

    // Where the shift register takes its next frame from at frame load.
    typedef enum logic [1:0] {
        SRC_LAST,
        SRC_HOLD,
        SRC_INPUT
    } load_src_t;

    // Left word occupies the upper half so it leaves the shifter first.
    function automatic logic [FRAME_BITS-1:0] pack_frame(input stereo_t pair);
        return {pair.left, pair.right};
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides clk down to the I2S bit clock and strobes the
// single clk edge on which that bit clock rises or falls.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 9
) (
    input  logic clk,
    input  logic reset,
    output logic bck,
    output logic bck_fall,
    output logic bck_rise
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             bck_q;
    logic             terminal;

    assign terminal = (div_q == DIV_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            bck_q <= 1'b0;
        end else if (terminal) begin
            div_q <= '0;
            bck_q <= ~bck_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Strobes mark the edge on which bck is about to toggle, so downstream
    // registers change on exactly the same edge as the bit clock.
    assign bck_fall = !reset && terminal && bck_q;
    assign bck_rise = !reset && terminal && !bck_q;
    assign bck      = bck_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S stereo transmitter: one-entry sample holding register, frame position
// counter and 32-bit MSB-first shifter driven off the i2s_clkgen strobes.
module i2s_audio_tx #(
    parameter int CLK_DIV  = 9,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                i2s_bck,
    output logic                i2s_lrck,
    output logic                i2s_data,
    output logic                underrun
);

    import i2s_pkg::FRAME_BITS;
    import i2s_pkg::POS_W;
    import i2s_pkg::stereo_t;
    import i2s_pkg::hold_state_t;
    import i2s_pkg::HOLD_EMPTY;
    import i2s_pkg::HOLD_FULL;
    import i2s_pkg::load_src_t;
    import i2s_pkg::SRC_LAST;
    import i2s_pkg::SRC_HOLD;
    import i2s_pkg::SRC_INPUT;
    import i2s_pkg::pack_frame;

    logic bck;
    logic bck_fall;
    logic bck_rise_unused;

    i2s_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .bck      (bck),
        .bck_fall (bck_fall),
        .bck_rise (bck_rise_unused)
    );

    hold_state_t           hold_state_q;
    hold_state_t           hold_next;
    stereo_t               hold_q;
    stereo_t               last_q;
    stereo_t               in_pair;
    stereo_t               load_pair;
    load_src_t             load_src;
    logic [POS_W-1:0]      b_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  ready_q;
    logic                  underrun_q;
    logic                  accept;
    logic                  frame_load;
    logic                  capture;
    logic                  starve;

    assign in_pair    = '{left: left_in, right: right_in};
    assign accept     = sample_valid && ready_q;
    // Frame load is the falling edge that moves the position from 0 to 1.
    assign frame_load = bck_fall && (b_q == '0);

    // NOTE: every signal written here is given a default first so no latch is inferred.
    always_comb begin
        hold_next = hold_state_q;
        load_src  = SRC_LAST;
        capture   = 1'b0;
        starve    = 1'b0;
        load_pair = last_q;
        unique case (hold_state_q)
            HOLD_EMPTY: begin
                if (frame_load) begin
                    if (accept) begin
                        load_src = SRC_INPUT;
                    end else begin
                        starve = 1'b1;
                    end
                end else if (accept) begin
                    hold_next = HOLD_FULL;
                    capture   = 1'b1;
                end
            end
            HOLD_FULL: begin
                if (frame_load) begin
                    load_src  = SRC_HOLD;
                    hold_next = HOLD_EMPTY;
                end
            end
            default: hold_next = HOLD_EMPTY;
        endcase
        unique case (load_src)
            SRC_HOLD:  load_pair = hold_q;
            SRC_INPUT: load_pair = in_pair;
            default:   load_pair = last_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_state_q <= HOLD_EMPTY;
            ready_q      <= 1'b0;
            underrun_q   <= 1'b0;
            b_q          <= '0;
            shift_q      <= '0;
            last_q       <= '0;
        end else begin
            hold_state_q <= hold_next;
            ready_q      <= (hold_next == HOLD_EMPTY);
            underrun_q   <= starve;
            if (bck_fall) begin
                b_q <= b_q + 1'b1;
                if (frame_load) begin
                    shift_q <= pack_frame(load_pair);
                    last_q  <= load_pair;
                end else begin
                    shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    // NOTE: the holding payload has no reset; hold_state_q alone says whether it is valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            hold_q <= in_pair;
        end
    end

    assign sample_ready = ready_q;
    assign i2s_bck      = bck;
    assign i2s_lrck     = b_q[POS_W-1];
    assign i2s_data     = shift_q[FRAME_BITS-1];
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx at CLK_DIV=2: each phase starts from reset
// and compares every clk against hand-derived bit clock, framing and data.
module tb_i2s_audio_tx;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        i2s_bck;
    logic        i2s_lrck;
    logic        i2s_data;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_word [3];
    logic [2:0]  exp_unr;
    logic [31:0] feed     [4];

    i2s_audio_tx #(
        .CLK_DIV  (CLK_DIV),
        .SAMPLE_W (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .left_in      (left_in),
        .right_in     (right_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bck      (i2s_bck),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        left_in      = '0;
        right_in     = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {27'd0, sample_ready, i2s_bck, i2s_lrck, i2s_data, underrun}, 32'd0);
        reset = 1'b0;
    endtask

    // Mode 0: no samples; 1: pair at k=1; 2: valid always high with feed[];
    // 3: pair only on the frame-1 load cycle; 4: pair mid-frame 0.
    // Sample k is taken at the negedge after the k-th rising edge post reset.
    task automatic run_phase(input string name, input int mode, input int ncyc, input int exp_acc);
        int          e_bck, e_lrck, e_data, e_unr, e_rdy, n_acc;
        int          b, f, rise1, rise2;
        logic        prev_lrck, bck_e, lrck_e, data_e, unr_e, rdy_e;
        logic [31:0] w;
        e_bck = 0; e_lrck = 0; e_data = 0; e_unr = 0; e_rdy = 0; n_acc = 0;
        rise1 = -1; rise2 = -1; prev_lrck = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            b      = (k / 4) % 32;
            f      = (k < 4) ? 0 : (k - 4) / 128;
            w      = exp_word[f];
            bck_e  = ((k / 2) % 2) == 1;
            lrck_e = (b >= 16);
            data_e = (k < 4) ? 1'b0 : ((b == 0) ? w[0] : w[32 - b]);
            unr_e  = (k >= 4) && ((k - 4) % 128 == 0) && exp_unr[f];
            case (mode)
                1:       rdy_e = !(k == 2 || k == 3);
                2:       rdy_e = (k == 1) || (k >= 4 && (k - 4) % 128 == 0);
                4:       rdy_e = !(k >= 21 && k <= 131);
                default: rdy_e = 1'b1;
            endcase
            if (i2s_bck !== bck_e)       e_bck++;
            if (i2s_lrck !== lrck_e)     e_lrck++;
            if (i2s_data !== data_e)     e_data++;
            if (underrun !== unr_e)      e_unr++;
            if (sample_ready !== rdy_e)  e_rdy++;
            if (i2s_lrck && !prev_lrck) begin
                if (rise1 < 0)      rise1 = k;
                else if (rise2 < 0) rise2 = k;
            end
            prev_lrck    = i2s_lrck;
            sample_valid = 1'b0;
            case (mode)
                1: if (k == 1) begin
                    sample_valid = 1'b1;
                    {left_in, right_in} = exp_word[0];
                end
                2: begin
                    sample_valid = 1'b1;
                    {left_in, right_in} = feed[n_acc % 4];
                end
                3: if (k == 131) begin
                    sample_valid = 1'b1;
                    {left_in, right_in} = exp_word[1];
                end
                4: if (k == 20) begin
                    sample_valid = 1'b1;
                    {left_in, right_in} = exp_word[1];
                end
                default: ;
            endcase
            if (sample_valid && sample_ready) n_acc++;
        end
        check({name, "_bck_errs"}, e_bck, 0);
        check({name, "_lrck_errs"}, e_lrck, 0);
        check({name, "_data_errs"}, e_data, 0);
        check({name, "_underrun_errs"}, e_unr, 0);
        check({name, "_ready_errs"}, e_rdy, 0);
        check({name, "_accepts"}, n_acc, exp_acc);
        if (ncyc >= 200) begin
            check({name, "_lrck_first_rise"}, rise1, 64);
            check({name, "_lrck_period"}, rise2 - rise1, 128);
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        // Idle after reset: zero data, one underrun at every frame load.
        exp_word[0] = 32'h0; exp_word[1] = 32'h0; exp_word[2] = 32'h0;
        exp_unr = 3'b111;
        apply_reset();
        run_phase("idle", 0, 384, 0);

        // Pair held before first load; later frames replay it with underrun.
        exp_word[0] = 32'h8001_7FFE; exp_word[1] = 32'h8001_7FFE; exp_word[2] = 32'h8001_7FFE;
        exp_unr = 3'b110;
        apply_reset();
        run_phase("pair", 1, 384, 1);

        // Continuous valid: one accept per frame, never an underrun.
        feed[0] = 32'h0F0F_F0F0; feed[1] = 32'h8000_7FFF;
        feed[2] = 32'hFFFF_0000; feed[3] = 32'h1357_9BDF;
        exp_word[0] = feed[0]; exp_word[1] = feed[1]; exp_word[2] = feed[2];
        exp_unr = 3'b000;
        apply_reset();
        run_phase("stream", 2, 384, 4);

        // Valid only on the frame-load cycle: bypass into the shifter.
        exp_word[0] = 32'h0; exp_word[1] = 32'hCAFE_0F0F; exp_word[2] = 32'hCAFE_0F0F;
        exp_unr = 3'b101;
        apply_reset();
        run_phase("bypass", 3, 384, 1);

        // Mid-frame feed: used at the next load, then repeated with underrun.
        exp_word[0] = 32'h0; exp_word[1] = 32'h1234_5678; exp_word[2] = 32'h1234_5678;
        exp_unr = 3'b101;
        apply_reset();
        run_phase("repeat", 4, 384, 1);

        // Abort at b=20 while lrck and data are both high.
        exp_word[0] = 32'h8001_7FFE; exp_word[1] = 32'h8001_7FFE; exp_word[2] = 32'h8001_7FFE;
        exp_unr = 3'b110;
        apply_reset();
        run_phase("pre_abort", 1, 82, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", {27'd0, sample_ready, i2s_bck, i2s_lrck, i2s_data, underrun}, 32'd0);

        exp_word[0] = 32'h0; exp_word[1] = 32'h0; exp_word[2] = 32'h0;
        exp_unr = 3'b111;
        apply_reset();
        run_phase("restart", 0, 384, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
